// File: rtl/multi_acc_datapath.sv
// multi_acc_datapath
//   NUM_ACC independent (WIDTH+1)-bit accumulators behind a valid/ready
//   command port. Single-cycle LOAD/ADD/SUB/CLR/CLRALL/READ, plus a
//   WIDTH-cycle shift-add MUL. Arithmetic wraps (SAT=0) or saturates
//   unsigned (SAT=1); overflow/underflow is reported with done.
//
// Ports
//   clock        rising-edge clock
//   rst_n        synchronous active-low reset
//   i_cmd_valid  command present
//   o_cmd_ready  block can accept a command (low while a MUL runs)
//   i_cmd        opcode (000 READ, 001 LOAD, 010 ADD, 011 CLR, 100 SUB,
//                101 MUL, 110 CLRALL, 111 reserved = READ)
//   i_sel        target accumulator
//   i_d_in       unsigned operand
//   o_result     target accumulator value after the last completed command
//   o_done       one-cycle completion pulse
//   o_ovf        overflow/underflow flag, qualified by o_done
module multi_acc_datapath #(
  parameter int WIDTH   = 4,
  parameter int NUM_ACC = 4,
  parameter int SAT     = 0,
  parameter int SEL_W   = $clog2(NUM_ACC)
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [2:0]       i_cmd,
  input  logic [SEL_W-1:0] i_sel,
  input  logic [WIDTH-1:0] i_d_in,
  output logic [WIDTH:0]   o_result,
  output logic             o_done,
  output logic             o_ovf
);

  localparam int ACC_W  = WIDTH + 1;
  localparam int PROD_W = 2 * WIDTH + 1;
  localparam int CNT_W  = $clog2(WIDTH) + 1;
  localparam int SELX_W = SEL_W + 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(WIDTH - 1);
  localparam logic [SELX_W-1:0] NUM_ACC_L = SELX_W'(NUM_ACC);

  localparam logic [2:0] OP_LOAD   = 3'b001;
  localparam logic [2:0] OP_ADD    = 3'b010;
  localparam logic [2:0] OP_CLR    = 3'b011;
  localparam logic [2:0] OP_SUB    = 3'b100;
  localparam logic [2:0] OP_MUL    = 3'b101;
  localparam logic [2:0] OP_CLRALL = 3'b110;

  typedef enum logic {ST_IDLE = 1'b0, ST_MUL = 1'b1} state_t;

  state_t r_state, w_state_next;

  logic [ACC_W-1:0]  r_acc [NUM_ACC];
  logic [ACC_W-1:0]  r_result;
  logic              r_done;
  logic              r_ovf;
  logic [PROD_W-1:0] r_mcand;
  logic [PROD_W-1:0] r_prod;
  logic [WIDTH-1:0]  r_mplier;
  logic [CNT_W-1:0]  r_cnt;
  logic [SEL_W-1:0]  r_sel;

  logic              w_accept;
  logic              w_sel_ok;
  logic [ACC_W-1:0]  w_sel_acc;
  logic [ACC_W:0]    w_sum;
  logic [ACC_W-1:0]  w_diff;
  logic              w_sub_uf;
  logic [PROD_W-1:0] w_prod_next;
  logic              w_prod_ovf;
  logic              w_mul_start;
  logic              w_mul_step;
  logic              w_wr_en;
  logic              w_wr_all;
  logic [SEL_W-1:0]  w_wr_sel;
  logic [ACC_W-1:0]  w_wr_val;
  logic              w_res_en;
  logic [ACC_W-1:0]  w_res_val;
  logic              w_done_next;
  logic              w_ovf_next;

  // Replace the wrapped value by the clamp limit only in saturating builds.
  function automatic logic [ACC_W-1:0] sat_val(input logic             ovf,
                                                input logic [ACC_W-1:0] wrapped,
                                                input logic [ACC_W-1:0] limit);
    if (ovf && (SAT != 0)) begin
      return limit;
    end else begin
      return wrapped;
    end
  endfunction

  assign w_accept  = i_cmd_valid && (r_state == ST_IDLE);
  assign w_sel_ok  = ({1'b0, i_sel} < NUM_ACC_L);
  assign w_sel_acc = w_sel_ok ? r_acc[i_sel] : '0;
  assign w_sum     = {1'b0, w_sel_acc} + {2'b00, i_d_in};
  assign w_diff    = w_sel_acc - {1'b0, i_d_in};
  assign w_sub_uf  = ({1'b0, i_d_in} > w_sel_acc);

  // One shift-add step: r_mcand is pre-shifted, so only bit 0 of the multiplier matters.
  assign w_prod_next = r_prod + (r_mplier[0] ? r_mcand : {PROD_W{1'b0}});
  assign w_prod_ovf  = |w_prod_next[PROD_W-1:ACC_W];

  // Next-state and command decode
  always_comb begin
    w_state_next = r_state;
    w_mul_start  = 1'b0;
    w_mul_step   = 1'b0;
    w_wr_en      = 1'b0;
    w_wr_all     = 1'b0;
    w_wr_sel     = i_sel;
    w_wr_val     = '0;
    w_res_en     = 1'b0;
    w_res_val    = r_result;
    w_done_next  = 1'b0;
    w_ovf_next   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_done_next = 1'b1;
          if (w_sel_ok) begin
            w_res_en = 1'b1;
            case (i_cmd)
              OP_LOAD: begin
                w_wr_en   = 1'b1;
                w_wr_val  = {1'b0, i_d_in};
                w_res_val = w_wr_val;
              end
              OP_ADD: begin
                w_wr_en    = 1'b1;
                w_ovf_next = w_sum[ACC_W];
                w_wr_val   = sat_val(w_sum[ACC_W], w_sum[ACC_W-1:0], {ACC_W{1'b1}});
                w_res_val  = w_wr_val;
              end
              OP_SUB: begin
                w_wr_en    = 1'b1;
                w_ovf_next = w_sub_uf;
                w_wr_val   = sat_val(w_sub_uf, w_diff, {ACC_W{1'b0}});
                w_res_val  = w_wr_val;
              end
              OP_CLR: begin
                w_wr_en   = 1'b1;
                w_wr_val  = '0;
                w_res_val = '0;
              end
              OP_CLRALL: begin
                w_wr_all  = 1'b1;
                w_res_val = '0;
              end
              OP_MUL: begin
                // Completion is reported by the MUL state instead.
                w_res_en     = 1'b0;
                w_done_next  = 1'b0;
                w_mul_start  = 1'b1;
                w_state_next = ST_MUL;
              end
              default: begin
                // READ and the reserved opcode
                w_res_val = w_sel_acc;
              end
            endcase
          end else begin
            // Out-of-range target: complete with no side effects.
            w_res_en = 1'b0;
          end
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_MUL: begin
        w_mul_step = 1'b1;
        w_wr_sel   = r_sel;
        if (r_cnt == CNT_LAST) begin
          w_wr_en      = 1'b1;
          w_wr_val     = sat_val(w_prod_ovf, w_prod_next[ACC_W-1:0], {ACC_W{1'b1}});
          w_res_en     = 1'b1;
          w_res_val    = w_wr_val;
          w_done_next  = 1'b1;
          w_ovf_next   = w_prod_ovf;
          w_state_next = ST_IDLE;
        end else begin
          w_state_next = ST_MUL;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Accumulator bank
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_ACC; i++) begin
      if (!rst_n || w_wr_all) begin
        r_acc[i] <= '0;
      end else if (w_wr_en && (w_wr_sel == SEL_W'(i))) begin
        r_acc[i] <= w_wr_val;
      end else begin
        r_acc[i] <= r_acc[i];
      end
    end
  end

  // Result and completion flags
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      r_result <= '0;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_res_en) begin
        r_result <= w_res_val;
      end else begin
        r_result <= r_result;
      end
      r_done <= w_done_next;
      r_ovf  <= w_ovf_next;
    end
  end

  // Multiplier operands, partial product and iteration counter
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
      r_cnt    <= '0;
      r_sel    <= '0;
    end else if (w_mul_start) begin
      r_mcand  <= PROD_W'(w_sel_acc);
      r_mplier <= i_d_in;
      r_prod   <= '0;
      r_cnt    <= '0;
      r_sel    <= i_sel;
    end else if (w_mul_step) begin
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_prod   <= w_prod_next;
      r_cnt    <= r_cnt + CNT_W'(1);
    end else begin
      r_mcand  <= r_mcand;
      r_mplier <= r_mplier;
      r_prod   <= r_prod;
      r_cnt    <= r_cnt;
      r_sel    <= r_sel;
    end
  end

  assign o_cmd_ready = (r_state == ST_IDLE);
  assign o_result    = r_result;
  assign o_done      = r_done;
  assign o_ovf       = r_ovf;

endmodule

// File: tb/tb_multi_acc_datapath.sv
// Bench for multi_acc_datapath: one wrapping and one saturating instance share
// the same stimulus; each has its own expected-response queue and monitor.
module tb_multi_acc_datapath;

  localparam int WIDTH   = 4;
  localparam int NUM_ACC = 4;
  localparam int SEL_W   = 2;
  localparam int ACC_W   = WIDTH + 1;

  localparam logic [2:0] OP_READ   = 3'b000;
  localparam logic [2:0] OP_LOAD   = 3'b001;
  localparam logic [2:0] OP_ADD    = 3'b010;
  localparam logic [2:0] OP_CLR    = 3'b011;
  localparam logic [2:0] OP_SUB    = 3'b100;
  localparam logic [2:0] OP_MUL    = 3'b101;
  localparam logic [2:0] OP_CLRALL = 3'b110;
  localparam logic [2:0] OP_RSVD   = 3'b111;

  typedef struct packed {
    logic [ACC_W-1:0] res;
    logic             ovf;
  } exp_t;

  logic             clock = 1'b0;
  logic             rst_n = 1'b0;
  logic             i_cmd_valid = 1'b0;
  logic [2:0]       i_cmd = 3'b000;
  logic [SEL_W-1:0] i_sel = 2'd0;
  logic [WIDTH-1:0] i_d_in = 4'd0;

  logic             w_ready_w, w_done_w, w_ovf_w;
  logic [ACC_W-1:0] w_res_w;
  logic             w_ready_s, w_done_s, w_ovf_s;
  logic [ACC_W-1:0] w_res_s;

  exp_t q_wrap[$];
  exp_t q_sat[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clock = ~clock;

  multi_acc_datapath #(.WIDTH(WIDTH), .NUM_ACC(NUM_ACC), .SAT(0)) u_wrap (
    .clock(clock), .rst_n(rst_n), .i_cmd_valid(i_cmd_valid), .o_cmd_ready(w_ready_w),
    .i_cmd(i_cmd), .i_sel(i_sel), .i_d_in(i_d_in),
    .o_result(w_res_w), .o_done(w_done_w), .o_ovf(w_ovf_w)
  );

  multi_acc_datapath #(.WIDTH(WIDTH), .NUM_ACC(NUM_ACC), .SAT(1)) u_sat (
    .clock(clock), .rst_n(rst_n), .i_cmd_valid(i_cmd_valid), .o_cmd_ready(w_ready_s),
    .i_cmd(i_cmd), .i_sel(i_sel), .i_d_in(i_d_in),
    .o_result(w_res_s), .o_done(w_done_s), .o_ovf(w_ovf_s)
  );

  // Monitor for the wrapping instance
  always @(negedge clock) begin
    if (w_done_w) begin
      exp_t e;
      checks++;
      if (q_wrap.size() == 0) begin
        errors++;
        $display("FAIL wrap_unexpected_done result=%0d ovf=%0d", w_res_w, w_ovf_w);
      end else begin
        e = q_wrap.pop_front();
        if (w_res_w !== e.res || w_ovf_w !== e.ovf) begin
          errors++;
          $display("FAIL wrap_result got=%0d/ovf%0d exp=%0d/ovf%0d t=%0t",
                   w_res_w, w_ovf_w, e.res, e.ovf, $time);
        end
      end
    end else if (w_ovf_w !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL wrap_ovf_without_done ovf=%0d exp=0", w_ovf_w);
    end
  end

  // Monitor for the saturating instance
  always @(negedge clock) begin
    if (w_done_s) begin
      exp_t e;
      checks++;
      if (q_sat.size() == 0) begin
        errors++;
        $display("FAIL sat_unexpected_done result=%0d ovf=%0d", w_res_s, w_ovf_s);
      end else begin
        e = q_sat.pop_front();
        if (w_res_s !== e.res || w_ovf_s !== e.ovf) begin
          errors++;
          $display("FAIL sat_result got=%0d/ovf%0d exp=%0d/ovf%0d t=%0t",
                   w_res_s, w_ovf_s, e.res, e.ovf, $time);
        end
      end
    end else if (w_ovf_s !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL sat_ovf_without_done ovf=%0d exp=0", w_ovf_s);
    end
  end

  task automatic check_bit(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!(w_ready_w && w_ready_s) && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    if (!(w_ready_w && w_ready_s)) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout ready=%0d/%0d exp=1", w_ready_w, w_ready_s);
    end
  endtask

  // Issue one command and queue the hand-computed responses of both builds.
  task automatic send(input logic [2:0] op, input logic [SEL_W-1:0] sel,
                      input logic [WIDTH-1:0] d,
                      input logic [ACC_W-1:0] ew, input logic ow,
                      input logic [ACC_W-1:0] es, input logic os);
    wait_ready();
    i_cmd = op; i_sel = sel; i_d_in = d; i_cmd_valid = 1'b1;
    q_wrap.push_back({ew, ow});
    q_sat.push_back({es, os});
    @(posedge clock); #1;
    i_cmd_valid = 1'b0;
  endtask

  task automatic send_same(input logic [2:0] op, input logic [SEL_W-1:0] sel,
                           input logic [WIDTH-1:0] d,
                           input logic [ACC_W-1:0] e, input logic o);
    send(op, sel, d, e, o, e, o);
  endtask

  initial begin
    // Reset
    repeat (3) @(posedge clock);
    #1 rst_n = 1'b1;
    check_bit("reset_ready_w", w_ready_w, 1'b1);
    check_bit("reset_ready_s", w_ready_s, 1'b1);
    check_bit("reset_done_w", w_done_w, 1'b0);
    checks++;
    if (w_res_w !== 5'd0 || w_res_s !== 5'd0) begin
      errors++;
      $display("FAIL reset_result got=%0d/%0d exp=0", w_res_w, w_res_s);
    end

    send_same(OP_READ, 2'd2, 4'd0, 5'd0, 1'b0);

    // Back-to-back loads, then read back
    send_same(OP_LOAD, 2'd0, 4'd9, 5'd9, 1'b0);
    send_same(OP_LOAD, 2'd1, 4'd3, 5'd3, 1'b0);
    send_same(OP_READ, 2'd0, 4'd0, 5'd9, 1'b0);
    send_same(OP_READ, 2'd1, 4'd0, 5'd3, 1'b0);

    // ADD with and without overflow
    send_same(OP_ADD, 2'd0, 4'd15, 5'd24, 1'b0);
    send(OP_ADD, 2'd0, 4'd15, 5'd7, 1'b1, 5'd31, 1'b1);

    // SUB underflow and exact zero
    send(OP_SUB, 2'd1, 4'd5, 5'd30, 1'b1, 5'd0, 1'b1);
    send_same(OP_LOAD, 2'd1, 4'd3, 5'd3, 1'b0);
    send_same(OP_SUB, 2'd1, 4'd3, 5'd0, 1'b0);

    // MUL 6*5 with latency and busy behaviour
    send_same(OP_LOAD, 2'd2, 4'd6, 5'd6, 1'b0);
    send_same(OP_MUL, 2'd2, 4'd5, 5'd30, 1'b0);
    i_cmd = OP_LOAD; i_sel = 2'd0; i_d_in = 4'd1; i_cmd_valid = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      check_bit("mul_busy_ready_w", w_ready_w, 1'b0);
      check_bit("mul_busy_ready_s", w_ready_s, 1'b0);
      check_bit("mul_early_done", w_done_w, 1'b0);
      if (c == 4) begin
        i_cmd_valid = 1'b0;
      end
      @(posedge clock); #1;
    end
    check_bit("mul_done_at_4", w_done_w, 1'b1);
    check_bit("mul_ready_after", w_ready_w, 1'b1);
    // acc0 must not have taken the LOAD offered while busy
    send(OP_READ, 2'd0, 4'd0, 5'd7, 1'b0, 5'd31, 1'b0);

    // MUL overflow, exact 2^ACC_W product, and multiply by zero
    send_same(OP_LOAD, 2'd2, 4'd7, 5'd7, 1'b0);
    send(OP_MUL, 2'd2, 4'd5, 5'd3, 1'b1, 5'd31, 1'b1);
    send_same(OP_MUL, 2'd2, 4'd0, 5'd0, 1'b0);
    send_same(OP_LOAD, 2'd0, 4'd8, 5'd8, 1'b0);
    send(OP_MUL, 2'd0, 4'd4, 5'd0, 1'b1, 5'd31, 1'b1);

    // Reserved opcode reads; ADD up to the exact maximum, then past it
    send_same(OP_LOAD, 2'd1, 4'd11, 5'd11, 1'b0);
    send_same(OP_RSVD, 2'd1, 4'd5, 5'd11, 1'b0);
    send_same(OP_ADD, 2'd1, 4'd15, 5'd26, 1'b0);
    send_same(OP_ADD, 2'd1, 4'd5, 5'd31, 1'b0);
    send(OP_ADD, 2'd1, 4'd1, 5'd0, 1'b1, 5'd31, 1'b1);
    send(OP_SUB, 2'd1, 4'd0, 5'd0, 1'b0, 5'd31, 1'b0);

    // Channel independence
    send_same(OP_LOAD, 2'd0, 4'd1, 5'd1, 1'b0);
    send_same(OP_LOAD, 2'd1, 4'd2, 5'd2, 1'b0);
    send_same(OP_LOAD, 2'd2, 4'd3, 5'd3, 1'b0);
    send_same(OP_LOAD, 2'd3, 4'd4, 5'd4, 1'b0);
    send_same(OP_MUL, 2'd2, 4'd5, 5'd15, 1'b0);
    send_same(OP_READ, 2'd0, 4'd0, 5'd1, 1'b0);
    send_same(OP_READ, 2'd1, 4'd0, 5'd2, 1'b0);
    send_same(OP_READ, 2'd2, 4'd0, 5'd15, 1'b0);
    send_same(OP_READ, 2'd3, 4'd0, 5'd4, 1'b0);
    send_same(OP_CLR, 2'd3, 4'd9, 5'd0, 1'b0);
    send_same(OP_READ, 2'd0, 4'd0, 5'd1, 1'b0);
    send_same(OP_READ, 2'd1, 4'd0, 5'd2, 1'b0);
    send_same(OP_READ, 2'd2, 4'd0, 5'd15, 1'b0);
    send_same(OP_READ, 2'd3, 4'd0, 5'd0, 1'b0);
    send_same(OP_CLRALL, 2'd0, 4'd0, 5'd0, 1'b0);
    for (int i = 0; i < NUM_ACC; i++) begin
      send_same(OP_READ, SEL_W'(i), 4'd0, 5'd0, 1'b0);
    end

    // Reset during MUL: no completion expected
    send_same(OP_LOAD, 2'd3, 4'd9, 5'd9, 1'b0);
    wait_ready();
    i_cmd = OP_MUL; i_sel = 2'd3; i_d_in = 4'd3; i_cmd_valid = 1'b1;
    @(posedge clock); #1;
    i_cmd_valid = 1'b0;
    @(posedge clock); #1;
    rst_n = 1'b0;
    @(posedge clock); #1;
    rst_n = 1'b1;
    check_bit("rst_mul_ready_w", w_ready_w, 1'b1);
    check_bit("rst_mul_ready_s", w_ready_s, 1'b1);
    check_bit("rst_mul_done", w_done_w, 1'b0);
    repeat (4) @(posedge clock);
    #1;
    send_same(OP_READ, 2'd3, 4'd0, 5'd0, 1'b0);
    send_same(OP_READ, 2'd0, 4'd0, 5'd0, 1'b0);

    // Drain both scoreboards
    for (int n = 0; n < 20 && (q_wrap.size() != 0 || q_sat.size() != 0); n++) begin
      @(posedge clock); #1;
    end
    checks++;
    if (q_wrap.size() != 0 || q_sat.size() != 0) begin
      errors++;
      $display("FAIL missing_done pending=%0d/%0d exp=0/0", q_wrap.size(), q_sat.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
